xof_absorb_squeeze_ctrl: RTL and testbench

//  Generalised SHAKE front-end for ExpandA/ExpandS/ExpandMask-style sampling.

---
 rtl/xof_absorb_squeeze_ctrl.sv | 166 ++++++++++++++++
 tb/tb_xof_absorb_squeeze_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/xof_absorb_squeeze_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : xof_absorb_squeeze_ctrl
// Brief   : SHAKE128/256 one-block absorb and multi-block squeeze controller
//           for an external Keccak-f[1600] core. Option macro: XOF_STATE_TAP_EN
// Revision: 1.0 - initial release
// ============================================================================
module xof_absorb_squeeze_ctrl #(
    parameter int SEED_W      = 256,
    parameter int NONCE_BYTES = 2,
    parameter int BLK_CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     mode,
    input  logic [SEED_W-1:0]        seed,
    input  logic [8*NONCE_BYTES-1:0] nonce,
    input  logic [BLK_CNT_W-1:0]     nblocks,
    output logic                     busy,
    output logic                     perm_start,
    output logic [1599:0]            perm_state_out,
    input  logic [1599:0]            perm_state_in,
    input  logic                     perm_done,
    output logic [63:0]              lane_data,
    output logic                     lane_valid,
    input  logic                     lane_ready,
    output logic                     lane_last,
    output logic                     done
`ifdef XOF_STATE_TAP_EN
    ,
    output logic [1599:0]            state_tap
`endif
);
    localparam int c_PAD_BIT = SEED_W + 8*NONCE_BYTES;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_PERM    = 3'd2,
        ST_SQUEEZE = 3'd3,
        ST_FIN     = 3'd4
    } state_t;

    state_t                r_fsm;
    logic [1599:0]         r_state;
    logic                  r_mode;
    logic [BLK_CNT_W-1:0]  r_blk_left;
    logic [4:0]            r_idx;

    logic [1599:0]         w_absorb;
    logic [4:0]            w_last_idx;
    logic [4:0]            w_idx_nxt;
    logic [63:0]           w_lane_nxt;
    logic                  w_xfer;
    logic                  w_final_blk;

    // Padded single block: seed || nonce || 0x1F ... 0x80 at the last rate byte
    always_comb begin
        w_absorb                          = '0;
        w_absorb[SEED_W-1:0]              = seed;
        w_absorb[SEED_W +: 8*NONCE_BYTES] = nonce;
        w_absorb[c_PAD_BIT +: 8]          = 8'h1F;
        if (mode) begin
            w_absorb[8*135+7] = 1'b1;
        end else begin
            w_absorb[8*167+7] = 1'b1;
        end
    end

    assign w_last_idx  = r_mode ? 5'd16 : 5'd20;
    assign w_idx_nxt   = r_idx + 5'd1;
    assign w_xfer      = lane_valid & lane_ready;
    assign w_final_blk = (r_blk_left == BLK_CNT_W'(1));

    always_comb begin
        w_lane_nxt = '0;
        for (int l = 0; l < 25; l++) begin
            if (w_idx_nxt == 5'(l)) begin
                w_lane_nxt = r_state[64*l +: 64];
            end
        end
    end

    assign perm_state_out = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm      <= ST_IDLE;
            r_state    <= '0;
            r_mode     <= 1'b0;
            r_blk_left <= '0;
            r_idx      <= '0;
            busy       <= 1'b0;
            perm_start <= 1'b0;
            lane_data  <= '0;
            lane_valid <= 1'b0;
            lane_last  <= 1'b0;
            done       <= 1'b0;
`ifdef XOF_STATE_TAP_EN
            state_tap  <= '0;
`endif
        end else begin
            perm_start <= 1'b0;
            done       <= 1'b0;
            case (r_fsm)
                ST_IDLE: begin
                    if (start) begin
                        r_state    <= w_absorb;
                        r_mode     <= mode;
                        r_blk_left <= (nblocks == '0) ? BLK_CNT_W'(1) : nblocks;
                        busy       <= 1'b1;
                        r_fsm      <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    perm_start <= 1'b1;
                    r_fsm      <= ST_PERM;
                end
                ST_PERM: begin
                    if (perm_done) begin
                        r_state    <= perm_state_in;
                        r_idx      <= '0;
                        lane_data  <= perm_state_in[63:0];
                        lane_valid <= 1'b1;
                        lane_last  <= 1'b0;
                        r_fsm      <= ST_SQUEEZE;
`ifdef XOF_STATE_TAP_EN
                        state_tap  <= perm_state_in;
`endif
                    end
                end
                ST_SQUEEZE: begin
                    if (w_xfer) begin
                        if (r_idx == w_last_idx) begin
                            lane_valid <= 1'b0;
                            lane_last  <= 1'b0;
                            if (w_final_blk) begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                r_fsm <= ST_FIN;
                            end else begin
                                // Next block is a plain re-permutation of the held state
                                r_blk_left <= r_blk_left - BLK_CNT_W'(1);
                                perm_start <= 1'b1;
                                r_fsm      <= ST_PERM;
                            end
                        end else begin
                            r_idx     <= w_idx_nxt;
                            lane_data <= w_lane_nxt;
                            lane_last <= w_final_blk && (w_idx_nxt == w_last_idx);
                        end
                    end
                end
                ST_FIN: begin
                    r_fsm <= ST_IDLE;
                end
                default: begin
                    r_fsm <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_xof_absorb_squeeze_ctrl.sv
`default_nettype none
// Testbench for xof_absorb_squeeze_ctrl: stub Keccak core (state XOR lane pattern,
// 24-cycle latency), lane collector and directed runs against a byte-level model.
module tb_xof_absorb_squeeze_ctrl;
    localparam logic [255:0] c_SEED =
        256'h0f2e3d4c_5b6a7988_97a6b5c4_d3e2f102_1e2d3c4b_5a697887_96a5b4c3_d2e11f1c;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          mode;
    logic [255:0]  seed;
    logic [15:0]   nonce;
    logic [7:0]    nblocks;
    logic          busy;
    logic          perm_start;
    logic [1599:0] perm_state_out;
    logic [1599:0] perm_state_in;
    logic          perm_done;
    logic [63:0]   lane_data;
    logic          lane_valid;
    logic          lane_ready;
    logic          lane_last;
    logic          done;
`ifdef XOF_STATE_TAP_EN
    logic [1599:0] state_tap;
`endif

    always #5 clk = ~clk;

    xof_absorb_squeeze_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .mode           (mode),
        .seed           (seed),
        .nonce          (nonce),
        .nblocks        (nblocks),
        .busy           (busy),
        .perm_start     (perm_start),
        .perm_state_out (perm_state_out),
        .perm_state_in  (perm_state_in),
        .perm_done      (perm_done),
        .lane_data      (lane_data),
        .lane_valid     (lane_valid),
        .lane_ready     (lane_ready),
        .lane_last      (lane_last),
        .done           (done)
`ifdef XOF_STATE_TAP_EN
        ,
        .state_tap      (state_tap)
`endif
    );

    function automatic logic [1599:0] pat_vec();
        logic [1599:0] v;
        for (int l = 0; l < 25; l++) v[64*l +: 64] = 64'h9E37_79B9_7F4A_7C15 * 64'(l + 1);
        return v;
    endfunction

    // Stub core
    logic [1599:0] stub_buf;
    logic          stub_done;
    logic          spur_done;
    int            stub_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            stub_cnt  <= 0;
            stub_done <= 1'b0;
            stub_buf  <= '0;
        end else begin
            stub_done <= 1'b0;
            if (perm_start) begin
                stub_buf <= perm_state_out ^ pat_vec();
                stub_cnt <= 24;
            end else if (stub_cnt != 0) begin
                stub_cnt <= stub_cnt - 1;
                if (stub_cnt == 1) stub_done <= 1'b1;
            end
        end
    end
    assign perm_done     = stub_done | spur_done;
    assign perm_state_in = spur_done ? {25{64'hDEAD_BEEF_0BAD_F00D}} : stub_buf;

    // Collector, sampled on the falling edge
    int            cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [63:0]   q_data[$];
    bit            q_last[$];
    int            ps_cyc[$];
    logic [1599:0] ps_state[$];
    int            done_cyc[$];
    int            done_busy_cnt = 0;
    int            stab_bad = 0;
    int            last_xfer_cyc = 0;
    logic          prev_stall = 1'b0;
    logic [63:0]   prev_data = '0;
    always @(negedge clk) begin
        if (prev_stall && (!lane_valid || lane_data !== prev_data)) stab_bad <= stab_bad + 1;
        prev_stall <= lane_valid && !lane_ready;
        prev_data  <= lane_data;
        if (lane_valid && lane_ready) begin
            q_data.push_back(lane_data);
            q_last.push_back(lane_last);
            last_xfer_cyc <= cyc;
        end
        if (perm_start) begin
            ps_cyc.push_back(cyc);
            ps_state.push_back(perm_state_out);
        end
        if (done) begin
            done_cyc.push_back(cyc);
            if (busy) done_busy_cnt <= done_busy_cnt + 1;
        end
    end

    int checks = 0;
    int errors = 0;
    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic m, input logic [7:0] nb, input bit rnd, input bit glitch,
                          input logic [255:0] s, input logic [15:0] n);
        logic [7:0]    bytes_v [200];
        logic [1599:0] a;
        logic [1599:0] blk;
        logic [1599:0] ab;
        int rate, nbe, nx, b_x, b_ps, b_d, b_stab, b_db, st, w;
        rate   = m ? 17 : 21;
        nbe    = (nb == 8'd0) ? 1 : int'(nb);
        for (int k = 0; k < 200; k++) bytes_v[k] = 8'h00;
        for (int k = 0; k < 32; k++) bytes_v[k] = s[8*k +: 8];
        bytes_v[32] = n[7:0];
        bytes_v[33] = n[15:8];
        bytes_v[34] = 8'h1F;
        bytes_v[rate*8-1] = bytes_v[rate*8-1] | 8'h80;
        for (int k = 0; k < 200; k++) a[8*k +: 8] = bytes_v[k];
        b_x = q_data.size(); b_ps = ps_cyc.size(); b_d = done_cyc.size();
        b_stab = stab_bad; b_db = done_busy_cnt;

        @(posedge clk); #1;
        seed = s; nonce = n; mode = m; nblocks = nb; start = 1'b1; st = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        seed = ~s; nonce = ~n; mode = ~m; nblocks = 8'd5;
        check_val("busy_after_start", 64'(busy), 64'd1);

        w = 0;
        while (done_cyc.size() == b_d && w < 4000) begin
            lane_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start = (glitch && lane_valid && (q_data.size() - b_x == 5)) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
            w++;
        end
        check_val("done_timeout", 64'(w >= 4000), 64'd0);
        lane_ready = 1'b1;
        start = 1'b0;
        repeat (6) begin @(posedge clk); #1; end

        if (ps_state.size() > b_ps) begin
            ab = ps_state[b_ps];
            for (int l = 0; l < 25; l++)
                check_val($sformatf("absorb_lane%0d", l), ab[64*l +: 64], a[64*l +: 64]);
            check_val("perm_start_delay", 64'(ps_cyc[b_ps] - st), 64'd2);
        end else begin
            check_val("perm_start_seen", 64'd0, 64'd1);
        end
        check_val("perm_start_count", 64'(ps_cyc.size() - b_ps), 64'(nbe));
        nx = q_data.size() - b_x;
        check_val("lane_count", 64'(nx), 64'(nbe * rate));
        for (int i = 0; i < nx && i < nbe * rate; i++) begin
            blk = (((i / rate) % 2) == 0) ? (a ^ pat_vec()) : a;
            check_val($sformatf("lane%0d", i), q_data[b_x + i], blk[64*(i % rate) +: 64]);
            check_val($sformatf("last%0d", i), 64'(q_last[b_x + i]), 64'(i == nbe * rate - 1));
        end
        check_val("done_count", 64'(done_cyc.size() - b_d), 64'd1);
        if (done_cyc.size() > b_d)
            check_val("done_latency", 64'(done_cyc[b_d] - last_xfer_cyc), 64'd1);
        check_val("busy_low_at_done", 64'(done_busy_cnt - b_db), 64'd0);
        check_val("stall_stable", 64'(stab_bad - b_stab), 64'd0);
        check_val("idle_busy", 64'(busy), 64'd0);
`ifdef XOF_STATE_TAP_EN
        blk = (((nbe - 1) % 2) == 0) ? (a ^ pat_vec()) : a;
        check_val("state_tap", 64'(state_tap == blk), 64'd1);
`endif
    endtask

    initial begin
        int b_d, b_x, w;
        logic [1599:0] snap;
        rst = 1'b1; start = 1'b0; mode = 1'b0; seed = '0; nonce = '0; nblocks = '0;
        lane_ready = 1'b1; spur_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_perm_start", 64'(perm_start), 64'd0);
        check_val("rst_lane_valid", 64'(lane_valid), 64'd0);
        check_val("rst_lane_last", 64'(lane_last), 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_lane_data", lane_data, 64'd0);
        check_val("rst_state", 64'(|perm_state_out), 64'd0);
        rst = 1'b0;

        run_op(1'b0, 8'd1, 1'b0, 1'b0, c_SEED, 16'h0101);
        run_op(1'b1, 8'd1, 1'b0, 1'b0, c_SEED, 16'h0101);
        run_op(1'b0, 8'd3, 1'b0, 1'b0, c_SEED, 16'h0101);
        run_op(1'b0, 8'd0, 1'b0, 1'b0, c_SEED, 16'h0101);
        run_op(1'b0, 8'd3, 1'b1, 1'b0, c_SEED, 16'h0101);
        run_op(1'b1, 8'd2, 1'b1, 1'b1, ~c_SEED, 16'h3a5c);

        // Spurious perm_done while idle
        snap = perm_state_out;
        @(posedge clk); #1; spur_done = 1'b1;
        @(posedge clk); #1; spur_done = 1'b0;
        @(posedge clk); #1;
        check_val("spur_valid", 64'(lane_valid), 64'd0);
        check_val("spur_busy", 64'(busy), 64'd0);
        check_val("spur_state", 64'(perm_state_out == snap), 64'd1);

        // Abort mid-squeeze
        b_d = done_cyc.size(); b_x = q_data.size();
        @(posedge clk); #1;
        seed = c_SEED; nonce = 16'h0707; mode = 1'b0; nblocks = 8'd2; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        w = 0;
        while (q_data.size() - b_x < 5 && w < 400) begin @(posedge clk); #1; w++; end
        check_val("abort_reach", 64'(w >= 400), 64'd0);
        #2 rst = 1'b1;
        #1;
        check_val("abort_valid", 64'(lane_valid), 64'd0);
        check_val("abort_busy", 64'(busy), 64'd0);
        check_val("abort_perm_start", 64'(perm_start), 64'd0);
        @(posedge clk); #1; rst = 1'b0;
        repeat (40) begin @(posedge clk); #1; end
        check_val("abort_no_done", 64'(done_cyc.size() - b_d), 64'd0);
        check_val("abort_idle_valid", 64'(lane_valid), 64'd0);

        run_op(1'b1, 8'd1, 1'b1, 1'b0, c_SEED ^ {4{64'h0123_4567_89AB_CDEF}}, 16'h0203);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
